// File: rtl/conv2d_pkg.sv
// Shared Conv2d definitions: stream FSM encoding, default widths and the
// round / shift / saturate requantizer used at the output of the MAC array.
package conv2d_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ACC_WIDTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam logic signed [63:0] Q_ONE = 64'sd1;

    // Round-half-up, arithmetic shift, then clamp to a signed dw-bit range.
    // Works on 64 bits so any accumulator up to 62 bits cannot overflow the add.
    function automatic logic signed [63:0] quantize_sat(
        input logic signed [63:0] acc,
        input int                 shift,
        input int                 dw
    );
        logic signed [63:0] rounded;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] result;
        rounded = (acc + (Q_ONE <<< (shift - 1))) >>> shift;
        hi      = (Q_ONE <<< (dw - 1)) - Q_ONE;
        lo      = -(Q_ONE <<< (dw - 1));
        if (rounded > hi)
            result = hi;
        else if (rounded < lo)
            result = lo;
        else
            result = rounded;
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered single-clock FIFO without fall-through; pointers carry one extra
// wrap bit so full and empty are distinguishable without an occupancy counter.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A pop never frees space for a same-cycle push.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    // Head is forced to zero when empty so the stream outputs are clean after reset.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/output_line_streamer.sv
// Output end of the Conv2d stream: requantizes MAC results, buffers them and
// sends an IMAGE_SIZE x IMAGE_SIZE frame as AXI4-Stream. OUTPUT_STREAMER_RELU_EN fuses a ReLU.
module output_line_streamer
    import conv2d_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int FRAC_SHIFT = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic [7:0]                  IMAGE_SIZE,
    input  logic signed [ACC_WIDTH-1:0] din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic                        Done_1row,
    output logic                        Done_frame,
    output logic                        Busy,
    output state_t                      o_dbg_state
);

    state_t          r_state;
    logic [7:0]      r_size;
    logic [7:0]      r_col;
    logic [7:0]      r_row;

    logic [7:0]              w_size_m1;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_col_last;
    logic                    w_frame_last;
    logic [63:0]             w_din_ext;
    logic [DATA_WIDTH-1:0]   w_sat;
    logic [DATA_WIDTH-1:0]   w_pix;
    logic [DATA_WIDTH:0]     w_head;

    // 8-bit wrap makes a size of 0 behave as 256.
    assign w_size_m1    = r_size - 8'd1;
    assign din_ready    = (r_state == ST_STREAM) && !w_full;
    assign w_accept     = din_valid && din_ready;
    assign w_col_last   = (r_col == w_size_m1);
    assign w_frame_last = w_col_last && (r_row == w_size_m1);

    assign w_din_ext = {{(64-ACC_WIDTH){din[ACC_WIDTH-1]}}, din};
    assign w_sat     = DATA_WIDTH'(quantize_sat(w_din_ext, FRAC_SHIFT, DATA_WIDTH));

`ifdef OUTPUT_STREAMER_RELU_EN
    assign w_pix = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
    assign w_pix = w_sat;
`endif

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (Reset),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_wdata ({w_frame_last, w_pix}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = w_head[DATA_WIDTH];
    assign w_pop         = m_axis_tvalid && m_axis_tready;

    assign Done_1row   = w_accept && w_col_last;
    assign Done_frame  = (r_state == ST_DRAIN) && w_pop && m_axis_tlast;
    assign Busy        = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_size  <= '0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_size  <= IMAGE_SIZE;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            if (r_row == w_size_m1) begin
                                r_row   <= '0;
                                r_state <= ST_DRAIN;
                            end else begin
                                r_row <= r_row + 8'd1;
                            end
                        end else begin
                            r_col <= r_col + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (Done_frame)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_line_streamer.sv
// Bench for output_line_streamer: random/directed pixels are scored against a
// plain-arithmetic quantization model through an expected-beat queue.
module tb_output_line_streamer;

    logic        clk;
    logic        Reset;
    logic        Start;
    logic [7:0]  IMAGE_SIZE;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        Done_1row;
    logic        Done_frame;
    logic        Busy;
    conv2d_pkg::state_t dbg_state;

    output_line_streamer dut (
        .clk           (clk),
        .Reset         (Reset),
        .Start         (Start),
        .IMAGE_SIZE    (IMAGE_SIZE),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .Done_1row     (Done_1row),
        .Done_frame    (Done_frame),
        .Busy          (Busy),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- shared bench state ----------------
    logic [16:0] exp_q[$];
    logic [31:0] dir_din_q[$];
    logic [15:0] dir_exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cur_size = 1;
    int pix_idx  = 0;
    int row_cnt, frame_cnt, beat_cnt, last_cnt;
    int tready_mode = 0;  // 0: always ready, 1: never ready, 2: random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference quantizer: floor((d + 128) / 256), clamp to int16, optional ReLU.
    function automatic logic [15:0] model_q(input logic [31:0] d);
        longint v;
        longint q;
        v = longint'($signed(d)) + 128;
        q = v / 256;
        if ((v % 256 != 0) && (v < 0))
            q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
`ifdef OUTPUT_STREAMER_RELU_EN
        if (q < 0) q = 0;
`endif
        return 16'(q);
    endfunction

    // ---------------- downstream ready driver ----------------
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            case (tready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'b0;
                default: m_axis_tready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        stalled;
        logic [16:0] held;
        logic [16:0] e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!Reset) begin
                stalled = 1'b0;
            end else begin
                if (m_axis_tvalid && stalled)
                    check("hold_stable", {15'd0, m_axis_tlast, m_axis_tdata}, {15'd0, held});
                if (m_axis_tvalid && !m_axis_tready) begin
                    stalled = 1'b1;
                    held    = {m_axis_tlast, m_axis_tdata};
                end else begin
                    stalled = 1'b0;
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    beat_cnt++;
                    if (m_axis_tlast) last_cnt++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got 0x%0h with no beat expected", {m_axis_tlast, m_axis_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {15'd0, m_axis_tlast, m_axis_tdata}, {15'd0, e});
                    end
                end
                row_cnt   += int'(Done_1row);
                frame_cnt += int'(Done_frame);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame(input int size);
        @(negedge clk);
        Start      = 1'b1;
        IMAGE_SIZE = 8'(size);
        cur_size   = size;
        pix_idx    = 0;
        row_cnt    = 0;
        frame_cnt  = 0;
        beat_cnt   = 0;
        last_cnt   = 0;
        @(negedge clk);
        Start      = 1'b0;
        IMAGE_SIZE = 8'($urandom);
        #1;
        check("busy_after_start", {31'd0, Busy}, 32'd1);
    endtask

    task automatic drive_pixels(input int n, input bit rand_valid, input int budget,
                                input bit pulse_start, output int got);
        int          cyc;
        bit          have;
        bit          directed;
        logic [31:0] cand;
        logic [15:0] cexp;
        cyc  = 0;
        have = 0;
        directed = 0;
        cand = '0;
        cexp = '0;
        got  = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (!have) begin
                if (dir_din_q.size() > 0) begin
                    cand = dir_din_q[0];
                    cexp = dir_exp_q[0];
                    directed = 1;
                end else begin
                    if ($urandom_range(0, 3) == 0)
                        cand = $urandom;
                    else
                        cand = 32'($urandom_range(0, 32'h00FFFFFF)) - 32'h00800000;
                    cexp = model_q(cand);
                    directed = 0;
                end
                have = 1;
            end
            din       = cand;
            din_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (pulse_start) begin
                Start      = ($urandom_range(0, 63) == 0);
                IMAGE_SIZE = 8'($urandom_range(1, 200));
            end
            #1;
            if (din_valid && din_ready) begin
                exp_q.push_back({(pix_idx == cur_size * cur_size - 1), cexp});
                pix_idx++;
                got++;
                have = 0;
                if (directed) begin
                    void'(dir_din_q.pop_front());
                    void'(dir_exp_q.pop_front());
                end
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        Start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int cyc;
        cyc = 0;
        while (!(exp_q.size() == 0 && !Busy) && cyc < budget) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        check("drain_in_time", {31'd0, (exp_q.size() == 0 && !Busy)}, 32'd1);
    endtask

    task automatic check_frame(input int size);
        check("rows",    32'(row_cnt),   32'(size));
        check("frames",  32'(frame_cnt), 32'd1);
        check("beats",   32'(beat_cnt),  32'(size * size));
        check("lasts",   32'(last_cnt),  32'd1);
        check("idle",    {31'd0, Busy},  32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int got;
        Reset      = 1'b0;
        Start      = 1'b0;
        IMAGE_SIZE = 8'd0;
        din        = '0;
        din_valid  = 1'b0;
        row_cnt = 0; frame_cnt = 0; beat_cnt = 0; last_cnt = 0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_din_ready",  {31'd0, din_ready},     32'd0);
        check("rst_tvalid",     {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tlast",      {31'd0, m_axis_tlast},  32'd0);
        check("rst_tdata",      {16'd0, m_axis_tdata},  32'd0);
        check("rst_done_1row",  {31'd0, Done_1row},     32'd0);
        check("rst_done_frame", {31'd0, Done_frame},    32'd0);
        check("rst_busy",       {31'd0, Busy},          32'd0);
        @(negedge clk);
        Reset = 1'b1;

        // Single 4x4 frame, din = k*256 -> tdata = k, no backpressure.
        tready_mode = 0;
        for (int k = 0; k < 16; k++) begin
            dir_din_q.push_back(32'(k * 256));
            dir_exp_q.push_back(16'(k));
        end
        start_frame(4);
        drive_pixels(16, 0, 100, 0, got);
        check("f1_accepts", 32'(got), 32'd16);
        wait_idle(200);
        check_frame(4);

        // Quantization corner values, followed by random fill.
        dir_din_q.push_back(32'h00000180); dir_exp_q.push_back(16'd2);
        dir_din_q.push_back(32'h0000017F); dir_exp_q.push_back(16'd1);
        dir_din_q.push_back(32'h7FFFFFFF); dir_exp_q.push_back(16'h7FFF);
`ifdef OUTPUT_STREAMER_RELU_EN
        dir_din_q.push_back(32'h80000000); dir_exp_q.push_back(16'h0000);
        dir_din_q.push_back(32'hFFFFFF80); dir_exp_q.push_back(16'h0000);
        dir_din_q.push_back(32'hFFFFFE00); dir_exp_q.push_back(16'h0000);
`else
        dir_din_q.push_back(32'h80000000); dir_exp_q.push_back(16'h8000);
        dir_din_q.push_back(32'hFFFFFF80); dir_exp_q.push_back(16'h0000);
        dir_din_q.push_back(32'hFFFFFE00); dir_exp_q.push_back(16'hFFFE);
`endif
        start_frame(4);
        drive_pixels(16, 1, 400, 0, got);
        check("quant_accepts", 32'(got), 32'd16);
        wait_idle(200);
        check_frame(4);

        // Backpressure: downstream stalled, only FIFO_DEPTH inputs fit.
        tready_mode = 1;
        start_frame(4);
        drive_pixels(6, 0, 6, 0, got);
        check("bp_accepts", 32'(got), 32'd4);
        check("bp_din_ready", {31'd0, din_ready}, 32'd0);
        repeat (4) @(negedge clk);
        tready_mode = 0;
        drive_pixels(12, 0, 100, 0, got);
        check("bp_rest_accepts", 32'(got), 32'd12);
        wait_idle(200);
        check_frame(4);

        // 1x1 frame.
        start_frame(1);
        drive_pixels(1, 0, 20, 0, got);
        check("s1_accepts", 32'(got), 32'd1);
        wait_idle(100);
        check_frame(1);

        // Reset in the middle of a frame discards everything buffered.
        start_frame(4);
        drive_pixels(5, 0, 40, 0, got);
        check("mid_accepts", 32'(got), 32'd5);
        @(negedge clk);
        Reset = 1'b0;
        exp_q.delete();
        #2;
        check("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("mid_rst_busy",   {31'd0, Busy},          32'd0);
        @(negedge clk);
        Reset = 1'b1;
        #2;
        check("post_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("post_rst_busy",   {31'd0, Busy},          32'd0);
        start_frame(4);
        drive_pixels(16, 0, 100, 0, got);
        check("clean_accepts", 32'(got), 32'd16);
        wait_idle(200);
        check_frame(4);

        // Large frame with random handshakes and stray Start pulses.
        tready_mode = 2;
        start_frame(128);
        drive_pixels(16384, 1, 70000, 1, got);
        check("big_accepts", 32'(got), 32'd16384);
        wait_idle(2000);
        check_frame(128);
        tready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/output_line_streamer.md
Name: output_line_streamer

Overview:
- Output end of the Conv2d stream. Accepts per-pixel convolution results from the MAC array, whose input side is fed by the input line buffer.
- Quantizes each result from accumulator width to pixel width.
- Buffers results in a small FIFO and transmits them as an AXI4-Stream master.
- Marks tlast on the final pixel of an IMAGE_SIZE x IMAGE_SIZE frame. Propagates backpressure upstream through din_ready.

Parameters:
- DATA_WIDTH, 16, output pixel width (signed).
- ACC_WIDTH, 32, input accumulator width (signed).
- FRAC_SHIFT, 8, arithmetic right shift applied during quantization; must be 1..ACC_WIDTH-DATA_WIDTH.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of two, 2..16.

Ports:
- clk  in  1  single clock for all logic.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  one-cycle pulse; begins a frame; ignored unless in IDLE.
- IMAGE_SIZE  in  8  frame width and height in pixels; sampled on Start.
- din  in  ACC_WIDTH  signed accumulator result.
- din_valid  in  1  din is valid.
- din_ready  out  1  block accepts din this cycle; drives upstream m_axis_tready.
- m_axis_tdata  out  DATA_WIDTH  quantized pixel.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tlast  out  1  final pixel of the frame.
- m_axis_tready  in  1  downstream ready.
- Done_1row  out  1  one-cycle pulse when the last column of a row is accepted.
- Done_frame  out  1  one-cycle pulse when the tlast beat completes its handshake.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (Reset=0, asynchronous): FSM to IDLE; FIFO empty; column and row counters 0; size register 0.
  - Outputs at reset: din_ready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, Done_1row=0, Done_frame=0, Busy=0.
  - A reset mid-frame discards all buffered data. No partial tlast is emitted.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE -> STREAM on Start. Latch IMAGE_SIZE; clear counters.
  - STREAM -> DRAIN when the frame-last input (col=size-1 and row=size-1) is accepted.
  - DRAIN -> IDLE when the tlast beat handshakes; Done_frame pulses in that same cycle.
  - Start outside IDLE is ignored.
- Input handshake:
  - din_ready = (state==STREAM) && !fifo_full.
  - An input is accepted when din_valid && din_ready.
  - No push while full, even if a pop occurs in the same cycle.
- Counters: advance only on accept.
  - col wraps at size-1 and increments row; Done_1row pulses on that accept cycle.
  - Compares use 8-bit size-1, so IMAGE_SIZE=0 means 256. Legal range is 1..128.
- Quantization: combinational, applied at push.
  - t = din + 2^(FRAC_SHIFT-1), then arithmetic shift right by FRAC_SHIFT (round-half-up).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Each FIFO entry stores {last_flag, pixel}.
- FIFO and output:
  - FIFO is registered with no fall-through: an accepted input appears on m_axis_* at the earliest 1 cycle later.
  - m_axis_tvalid = !fifo_empty. m_axis_tdata and m_axis_tlast come from the head entry.
  - Pop on m_axis_tvalid && m_axis_tready.
  - Simultaneous push and pop with the FIFO non-full and non-empty keeps occupancy constant.
  - The pointers use one extra wrap bit to tell full from empty.
- AXI rule: while tvalid=1 and tready=0, tdata and tlast are held stable.
- Throughput: 1 pixel/cycle sustained when m_axis_tready=1.
- IMAGE_SIZE changes outside IDLE have no effect.

Optional Feature:
- Macro: OUTPUT_STREAMER_RELU_EN.
- Defined: after saturation, negative pixels are forced to 0 (ReLU fused into quantization). No change to latency.
- Undefined: signed saturated values pass unchanged.

Decomposition:
- Shared package conv2d_pkg:
  - FSM state encoding (IDLE/STREAM/DRAIN).
  - Default DATA_WIDTH and ACC_WIDTH constants.
  - The quantize/saturate function (round, shift, clamp), shared with any future requantizer.
- One natural sub-module: sync_fifo (parameterized width and depth; push, pop, full, empty).

Test Plan:
- Reset mid-STREAM:
  - Stimulus: Start with IMAGE_SIZE=4, accept 5 pixels, assert Reset=0 for 1 cycle.
  - Required: tvalid=0, Busy=0 next cycle. A new Start yields a clean 16-beat frame.
- Single frame, no backpressure:
  - Stimulus: IMAGE_SIZE=4, din_valid=1 continuously, m_axis_tready=1, din = k*256 for k=0..15.
  - Required: 16 beats with tdata=0..15; tlast only on beat 15; Done_1row pulses 4 times; Done_frame once; return to IDLE.
- Quantization:
  - Stimulus: din = 0x00000180, 0x0000017F, 0x7FFFFFFF, 0x80000000, 0xFFFFFF80.
  - Required: tdata = 2, 1, 32767, -32768, 0. Last value is 0 with or without RELU_EN.
  - With OUTPUT_STREAMER_RELU_EN: din = 0xFFFFFE00 -> 0; without it -> -2.
- Backpressure:
  - Stimulus: m_axis_tready=0 while pushing 6 inputs.
  - Required: din_ready falls after 4 accepts; tdata and tlast stay stable while stalled; releasing tready drains in order with no loss or duplication.
- Random handshake:
  - Stimulus: IMAGE_SIZE=128, random din_valid and m_axis_tready at 50% each.
  - Required: exactly 16384 beats in order; single tlast on the final beat; Start pulses during STREAM are ignored.
- IMAGE_SIZE=1:
  - Stimulus: one input.
  - Required: a single beat with tlast=1; Done_1row and Done_frame each pulse once.
